enemy_fire_scheduler: RTL and testbench
=======================================

ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 Parameter COOLDOWN_FRAMES, default 8, frames an enemy is blocked after a granted shot (1..15).
REQ-002 Parameter MAX_SPAWN_PER_FRAME, default 2, maximum bullets spawned per frame (1..15).
REQ-003 i_clk  input  1  single clock; all logic on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_frameTick  input  1  one-cycle pulse per video frame.
REQ-006 i_enemyState  input  15  per-enemy alive flag.
REQ-007 i_enemyPosition  input  285  15 x 19-bit; enemy k: x = [k*19+9 : k*19], y = [k*19+18 : k*19+10].
REQ-008 i_fireReq  input  15  per-enemy level fire request from the AI logic.
REQ-009 i_enemyBulletState  input  31  occupied flag per enemy bullet slot.
REQ-010 i_spawnAck  input  1  bullet engine accepted the current spawn.
REQ-011 o_spawnValid  output  1  spawn command valid.
REQ-012 o_spawnSlot  output  5  bullet slot index, 0..30.
REQ-013 o_spawnPos  output  19  bullet start position, same x/y packing as one enemy entry.
REQ-014 o_spawnEnemy  output  4  index of the firing enemy, 0..14.
REQ-015 o_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, ARB, ALLOC, and ISSUE, with exactly one state per cycle.
REQ-017 In IDLE, on i_frameTick, the block SHALL latch eligible = i_fireReq & i_enemyState & (cooldown==0), clear spawnCount, and enter ARB.
REQ-018 i_frameTick outside IDLE SHALL NOT re-snapshot; that frame's arbitration is skipped.
REQ-019 ARB (1 cycle) SHALL pick the first set eligible bit at index >= rrPtr, wrapping 14->0; if none, go to IDLE.
REQ-020 ARB SHALL skip, clear, and not cooldown a winner whose y+24 > 463, then re-arbitrate the next cycle.
REQ-021 ALLOC (1 cycle) SHALL pick the lowest index with i_enemyBulletState==0; if all 31 are occupied, it SHALL clear eligible and go to IDLE.
REQ-022 Spawn x SHALL be enemy x + 16, 10-bit modulo 1024.
REQ-023 Spawn y SHALL be enemy y + 24, 9-bit, guaranteed non-overflowing by REQ-020.
REQ-024 ISSUE SHALL hold o_spawnValid=1 with slot, position, and enemy stable until i_spawnAck is sampled high.
REQ-025 Exception to REQ-024: if the winning enemy's i_enemyState falls during ISSUE, o_spawnValid SHALL drop next cycle, that bit SHALL clear, no cooldown SHALL apply, and the FSM SHALL go to ARB.
REQ-026 On ack, the block SHALL clear the winner's eligible bit, load its cooldown with COOLDOWN_FRAMES, set rrPtr = (winner+1) mod 15, and increment spawnCount.
REQ-027 After REQ-026, if spawnCount == MAX_SPAWN_PER_FRAME or eligible == 0, the FSM SHALL go to IDLE; otherwise it SHALL go to ARB.
REQ-028 o_spawnValid SHALL deassert the cycle after ack; acks while o_spawnValid=0 SHALL be ignored.
REQ-029 The 15 x 4-bit cooldowns SHALL decrement on each i_frameTick, saturating at 0; a same-cycle load SHALL win over the decrement.
REQ-030 Ack-to-next-valid latency SHALL be 3 cycles (ack, ARB, ALLOC).
REQ-031 Tick-to-first-valid latency SHALL be 3 cycles (tick, ARB, ALLOC).

Reset
REQ-032 With i_rst high at a clock edge, the FSM SHALL go to IDLE, with o_spawnValid, o_spawnSlot, o_spawnPos, o_spawnEnemy, and o_busy all 0.
REQ-033 Reset SHALL also set every cooldown, rrPtr, spawnCount, and eligible to 0.
REQ-034 Reset during ISSUE SHALL abandon the spawn with no cooldown load.
REQ-035 Reset SHALL take priority over i_frameTick and i_spawnAck in the same cycle.

Verification
REQ-036 Basic spawn: enemy 3 alive and requesting at x=100, y=50, all slots free, tick, ack on the first valid -> o_spawnValid 3 cycles after tick, o_spawnSlot=0, o_spawnEnemy=3, o_spawnPos x=116 y=74, cooldown[3]=8.
REQ-037 Round-robin limit: enemies 0, 5, 14 requesting, MAX=2, immediate acks -> grants 0 then 5; next frame 14 is granted first; cooldown blocks 0 and 5 for 8 ticks.
REQ-038 Slot exhaustion: i_enemyBulletState=31'h7FFFFFFE with a request -> slot 0.
REQ-039 All slots full: i_enemyBulletState all ones with a request -> no o_spawnValid, o_busy returns to 0 after 2 cycles.
REQ-040 Backpressure and kill: ack withheld 10 cycles -> outputs stable throughout; enemy killed mid-ISSUE -> valid drops, no cooldown, next eligible enemy granted.
REQ-041 Boundary and reset: enemy y=440 skipped with the next enemy granted; i_rst during ISSUE -> all outputs 0 next cycle and cooldown unchanged at 0.

Source files
------------

// File: rtl/enemy_fire_scheduler.sv
// Per-frame enemy fire arbiter: snapshots eligible shooters on each frame tick,
// round-robins among them, allocates a free bullet slot and issues one spawn at a time.
module enemy_fire_scheduler #(
    parameter int COOLDOWN_FRAMES     = 8,
    parameter int MAX_SPAWN_PER_FRAME = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_frameTick,
    input  logic [14:0]  i_enemyState,
    input  logic [284:0] i_enemyPosition,
    input  logic [14:0]  i_fireReq,
    input  logic [30:0]  i_enemyBulletState,
    input  logic         i_spawnAck,
    output logic         o_spawnValid,
    output logic [4:0]   o_spawnSlot,
    output logic [18:0]  o_spawnPos,
    output logic [3:0]   o_spawnEnemy,
    output logic         o_busy
);
    localparam int NUM_EN   = 15;
    localparam int NUM_SLOT = 31;

    typedef enum logic [1:0] {S_IDLE, S_ARB, S_ALLOC, S_ISSUE} state_t;

    state_t             r_state, w_next;
    logic [14:0]        r_eligible;
    logic [14:0][3:0]   r_cool;
    logic [3:0]         r_rrPtr, r_spawnCount, r_winner;
    logic [4:0]         r_slot;
    logic [18:0]        r_pos;

    logic [14:0][18:0]  w_posArr;
    logic               w_arbFound, w_yOver, w_slotFound, w_ack, w_kill;
    logic [3:0]         w_arbIdx, w_countInc;
    logic [4:0]         w_sum, w_slotIdx;
    logic [18:0]        w_winPos;
    logic [14:0]        w_coolZero, w_eligAfter;

    assign w_posArr = i_enemyPosition;

    // Round-robin search starting at rrPtr, wrapping 14 -> 0
    always_comb begin
        w_arbFound = 1'b0;
        w_arbIdx   = 4'd0;
        w_sum      = 5'd0;
        for (int i = 0; i < NUM_EN; i++) begin
            w_sum = {1'b0, r_rrPtr} + 5'(i);
            if (w_sum >= 5'd15) w_sum = w_sum - 5'd15;
            if (!w_arbFound && r_eligible[w_sum[3:0]]) begin
                w_arbFound = 1'b1;
                w_arbIdx   = w_sum[3:0];
            end
        end
    end

    always_comb begin
        w_slotFound = 1'b0;
        w_slotIdx   = 5'd0;
        for (int i = 0; i < NUM_SLOT; i++) begin
            if (!w_slotFound && !i_enemyBulletState[i]) begin
                w_slotFound = 1'b1;
                w_slotIdx   = 5'(i);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_EN; k++) w_coolZero[k] = (r_cool[k] == 4'd0);
    end

    assign w_winPos    = w_posArr[w_arbIdx];
    // Bullet would start below the playfield (y + 24 > 463)
    assign w_yOver     = ({1'b0, w_winPos[18:10]} + 10'd24) > 10'd463;
    assign w_ack       = (r_state == S_ISSUE) && i_spawnAck;
    assign w_kill      = (r_state == S_ISSUE) && !i_spawnAck && !i_enemyState[r_winner];
    assign w_eligAfter = r_eligible & ~(15'd1 << r_winner);
    assign w_countInc  = r_spawnCount + 4'd1;

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (i_frameTick) w_next = S_ARB;
            S_ARB: begin
                if (!w_arbFound)  w_next = S_IDLE;
                else if (w_yOver) w_next = S_ARB;
                else              w_next = S_ALLOC;
            end
            S_ALLOC: w_next = w_slotFound ? S_ISSUE : S_IDLE;
            S_ISSUE: begin
                if (w_ack) begin
                    if (w_countInc == 4'(MAX_SPAWN_PER_FRAME) || w_eligAfter == 15'd0)
                        w_next = S_IDLE;
                    else
                        w_next = S_ARB;
                end else if (w_kill) begin
                    w_next = S_ARB;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy       = (r_state != S_IDLE);
        o_spawnValid = (r_state == S_ISSUE);
        o_spawnSlot  = o_spawnValid ? r_slot   : 5'd0;
        o_spawnPos   = o_spawnValid ? r_pos    : 19'd0;
        o_spawnEnemy = o_spawnValid ? r_winner : 4'd0;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_eligible   <= '0;
            r_cool       <= '0;
            r_rrPtr      <= '0;
            r_spawnCount <= '0;
            r_winner     <= '0;
            r_slot       <= '0;
            r_pos        <= '0;
        end else begin
            // A cooldown load on ack wins over the frame decrement
            for (int k = 0; k < NUM_EN; k++) begin
                if (w_ack && r_winner == 4'(k))
                    r_cool[k] <= 4'(COOLDOWN_FRAMES);
                else if (i_frameTick && !w_coolZero[k])
                    r_cool[k] <= r_cool[k] - 4'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (i_frameTick) begin
                        r_eligible   <= i_fireReq & i_enemyState & w_coolZero;
                        r_spawnCount <= 4'd0;
                    end
                end
                S_ARB: begin
                    if (w_arbFound) begin
                        if (w_yOver) begin
                            r_eligible[w_arbIdx] <= 1'b0;
                        end else begin
                            r_winner <= w_arbIdx;
                            r_pos    <= {w_winPos[18:10] + 9'd24, w_winPos[9:0] + 10'd16};
                        end
                    end
                end
                S_ALLOC: begin
                    if (w_slotFound) r_slot <= w_slotIdx;
                    else             r_eligible <= '0;
                end
                S_ISSUE: begin
                    if (w_ack) begin
                        r_eligible   <= w_eligAfter;
                        r_rrPtr      <= (r_winner == 4'd14) ? 4'd0 : r_winner + 4'd1;
                        r_spawnCount <= w_countInc;
                    end else if (w_kill) begin
                        r_eligible   <= w_eligAfter;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Scoreboard bench for enemy_fire_scheduler: expected spawns queued at stimulus time,
// compared on each rising edge of o_spawnValid.
module tb_enemy_fire_scheduler;
    logic         i_clk = 1'b0;
    logic         i_rst, i_frameTick, i_spawnAck;
    logic [14:0]  i_enemyState, i_fireReq;
    logic [284:0] i_enemyPosition;
    logic [30:0]  i_enemyBulletState;
    logic         o_spawnValid, o_busy;
    logic [4:0]   o_spawnSlot;
    logic [18:0]  o_spawnPos;
    logic [3:0]   o_spawnEnemy;

    always #5 i_clk = ~i_clk;

    enemy_fire_scheduler dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_frameTick(i_frameTick),
        .i_enemyState(i_enemyState), .i_enemyPosition(i_enemyPosition),
        .i_fireReq(i_fireReq), .i_enemyBulletState(i_enemyBulletState),
        .i_spawnAck(i_spawnAck), .o_spawnValid(o_spawnValid),
        .o_spawnSlot(o_spawnSlot), .o_spawnPos(o_spawnPos),
        .o_spawnEnemy(o_spawnEnemy), .o_busy(o_busy)
    );

    typedef struct packed {
        logic [4:0]  slot;
        logic [3:0]  en;
        logic [18:0] pos;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    logic prev_v = 1'b0;
    bit   f;
    int   n;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic push(input int slot, input int en, input int x, input int y);
        exp_t e;
        logic [9:0] xs;
        logic [8:0] ys;
        xs = 10'((x + 16) % 1024);
        ys = 9'(y + 24);
        e.slot = 5'(slot);
        e.en   = 4'(en);
        e.pos  = {ys, xs};
        sb.push_back(e);
    endtask

    task automatic enemy(input int k, input int x, input int y);
        i_enemyState[k] = 1'b1;
        i_fireReq[k]    = 1'b1;
        i_enemyPosition[k*19 +: 19] = {9'(y), 10'(x)};
    endtask

    task automatic cyc(input int c);
        repeat (c) @(negedge i_clk);
    endtask

    task automatic tick();
        i_frameTick = 1'b1;
        cyc(1);
        i_frameTick = 1'b0;
    endtask

    task automatic ack_now();
        i_spawnAck = 1'b1;
        cyc(1);
        i_spawnAck = 1'b0;
    endtask

    task automatic wait_valid(input int maxc, output bit found, output int cnt);
        cnt = 0;
        while (!o_spawnValid && cnt < maxc) begin
            cyc(1);
            cnt++;
        end
        found = o_spawnValid;
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_enemyState = '0; i_fireReq = '0; i_enemyPosition = '0; i_enemyBulletState = '0;
        cyc(2);
        i_rst = 1'b0;
        cyc(1);
    endtask

    always @(negedge i_clk) begin
        if (o_spawnValid && !prev_v) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected", 32'(o_spawnEnemy), 32'hFF);
            end else begin
                mon_e = sb.pop_front();
                chk("spawn_slot",  32'(o_spawnSlot),  32'(mon_e.slot));
                chk("spawn_enemy", 32'(o_spawnEnemy), 32'(mon_e.en));
                chk("spawn_pos",   32'(o_spawnPos),   32'(mon_e.pos));
            end
        end
        prev_v <= o_spawnValid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        i_rst = 1'b1; i_frameTick = 1'b0; i_spawnAck = 1'b0;
        i_enemyState = '0; i_fireReq = '0; i_enemyPosition = '0; i_enemyBulletState = '0;
        cyc(2);
        chk("rst_valid", 32'(o_spawnValid), 0);
        chk("rst_busy",  32'(o_busy), 0);
        chk("rst_slot",  32'(o_spawnSlot), 0);
        chk("rst_pos",   32'(o_spawnPos), 0);
        chk("rst_enemy", 32'(o_spawnEnemy), 0);
        i_rst = 1'b0;
        cyc(1);

        // Basic spawn
        enemy(3, 100, 50);
        push(0, 3, 100, 50);
        tick();
        wait_valid(10, f, n);
        chk("basic_found", 32'(f), 1);
        chk("tick_latency", n + 1, 3);
        ack_now();
        chk("drop_after_ack", 32'(o_spawnValid), 0);
        chk("basic_idle", 32'(o_busy), 0);
        chk("basic_cool", 32'(dut.r_cool[3]), 8);

        // Round-robin, per-frame limit and cooldown
        do_reset();
        enemy(0, 10, 20); enemy(5, 200, 100); enemy(14, 300, 200);
        push(0, 0, 10, 20); push(0, 5, 200, 100);
        tick();
        wait_valid(10, f, n);
        ack_now();
        wait_valid(10, f, n);
        chk("ack_latency", n + 1, 3);
        ack_now();
        chk("rr_max_idle", 32'(o_busy), 0);
        push(0, 14, 300, 200);
        tick();
        wait_valid(10, f, n);
        chk("rr_frame2", 32'(f), 1);
        ack_now();
        for (int t = 3; t <= 9; t++) begin
            tick();
            wait_valid(5, f, n);
            chk("cool_block", 32'(f), 0);
        end
        push(0, 0, 10, 20); push(0, 5, 200, 100);
        tick();
        wait_valid(10, f, n);
        chk("cool_release", 32'(f), 1);
        ack_now();
        wait_valid(10, f, n);
        ack_now();

        // Slot allocation
        do_reset();
        i_enemyBulletState = 31'h7FFFFFFE;
        enemy(2, 50, 60);
        push(0, 2, 50, 60);
        tick();
        wait_valid(10, f, n);
        ack_now();
        i_enemyBulletState = 31'h000000FF;
        enemy(7, 400, 10);
        push(8, 7, 400, 10);
        tick();
        wait_valid(10, f, n);
        chk("slot8_found", 32'(f), 1);
        ack_now();

        // All slots full
        do_reset();
        i_enemyBulletState = '1;
        enemy(1, 5, 5);
        tick();
        chk("full_busy_arb", 32'(o_busy), 1);
        cyc(2);
        chk("full_busy_idle", 32'(o_busy), 0);
        chk("full_novalid", 32'(o_spawnValid), 0);

        // Backpressure, then kill mid-ISSUE
        do_reset();
        enemy(4, 120, 80); enemy(9, 130, 90); enemy(11, 140, 100);
        push(0, 4, 120, 80);
        tick();
        wait_valid(10, f, n);
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            chk("hold", 32'({o_spawnValid, o_spawnSlot, o_spawnEnemy, o_spawnPos}),
                32'({1'b1, 5'd0, 4'd4, 9'd104, 10'd136}));
        end
        ack_now();
        push(0, 9, 130, 90);
        wait_valid(10, f, n);
        i_enemyState[9] = 1'b0;
        cyc(1);
        chk("kill_drop", 32'(o_spawnValid), 0);
        push(0, 11, 140, 100);
        wait_valid(10, f, n);
        chk("kill_regrant", 32'(f), 1);
        ack_now();
        chk("kill_nocool", 32'(dut.r_cool[9]), 0);
        chk("kill_idle", 32'(o_busy), 0);

        // y boundary skip and x wrap
        do_reset();
        enemy(6, 50, 440); enemy(8, 1015, 439);
        push(0, 8, 1015, 439);
        tick();
        wait_valid(10, f, n);
        chk("skip_found", 32'(f), 1);
        ack_now();

        // Reset during ISSUE beats tick and ack
        enemy(12, 60, 70);
        push(0, 12, 60, 70);
        tick();
        wait_valid(10, f, n);
        i_rst = 1'b1; i_frameTick = 1'b1; i_spawnAck = 1'b1;
        cyc(1);
        i_rst = 1'b0; i_frameTick = 1'b0; i_spawnAck = 1'b0;
        chk("rstiss_valid", 32'(o_spawnValid), 0);
        chk("rstiss_busy",  32'(o_busy), 0);
        chk("rstiss_out",   32'({o_spawnSlot, o_spawnPos, o_spawnEnemy}), 0);
        chk("rstiss_nocool", 32'(dut.r_cool[12]), 0);
        wait_valid(6, f, n);
        chk("rstiss_norespawn", 32'(f), 0);

        chk("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
